// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers.
//   state_e  : occupancy of a stage register (empty, one entry, main + skid entry)
//   mem_wb_t : MEM/WB payload; its $bits is the DATA_W used by that stage boundary
package pipe_pkg;

  localparam int unsigned PcW        = 32;
  localparam int unsigned XlenW      = 32;
  localparam int unsigned RegSelW    = 5;
  localparam int unsigned BranchCtrW = 2;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  typedef struct packed {
    logic [PcW-1:0]        pc;
    logic                  reg_write_en;
    logic [RegSelW-1:0]    reg_select;
    logic [BranchCtrW-1:0] branch_ctr;
    logic                  alu_src;
    logic [XlenW-1:0]      rd_data;
    logic [XlenW-1:0]      offset;
    logic                  zero;
  } mem_wb_t;

  localparam int unsigned MemWbW = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating stall counter.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   flush           : synchronous kill of held entries and of the current input beat
//   in_valid/ready  : upstream handshake, in_data payload
//   out_valid/ready : downstream handshake, out_data payload (main entry)
//   stall_cnt       : saturating count of cycles with out_valid && !out_ready
//   stall_clr       : synchronous clear of stall_cnt (wins over increment)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic in_fire;
  logic out_fire;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  // With the skid entry, in_ready is a pure decode of the state register so it
  // carries no combinational path from out_ready.
  if (SKID_EN) begin : g_skid
    assign in_ready = (state_q != StSkid);
  end else begin : g_no_skid
    assign in_ready = !out_valid || out_ready;
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = StFull;
        end
      end
      StFull: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire && SKID_EN) begin
          skid_d  = in_data;
          state_d = StSkid;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush only needs to invalidate; data registers may hold stale payload.
    // A beat leaving on out_fire in the same cycle is still delivered.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule
